// File: rtl/drive_safety_ctrl.sv
// drive_safety_ctrl: gates rover drive motors against front/back IR obstacle sensors.
// Synchronises and debounces the active-low IR inputs, accepts drive commands over a
// valid/ready handshake, blocks motion toward a detected obstacle and waits a fixed
// hold-off after it clears before resuming.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   disF/disB  raw front/back IR sensors, active-low, asynchronous
//   cmd_valid  command present
//   cmd_dir    00 STOP, 01 FWD, 10 REV, 11 reserved (STOP)
//   cmd_ready  command accepted when cmd_valid && cmd_ready (low only in HOLD)
//   motor_en   drive enable (FWD or REV)
//   motor_dir  1 = forward, 0 = reverse
//   detF/detB  debounced obstacle flags, active-high
//   blocked    high in BLOCK and HOLD
//   state      IDLE=0, FWD=1, REV=2, BLOCK=3, HOLD=4
//   block_cnt  saturating count of BLOCK entries from IDLE/FWD/REV
module drive_safety_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 8,
   parameter int unsigned RESUME_CYCLES   = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       disF,
   input  logic       disB,
   input  logic       cmd_valid,
   input  logic [1:0] cmd_dir,
   output logic       cmd_ready,
   output logic       motor_en,
   output logic       motor_dir,
   output logic       detF,
   output logic       detB,
   output logic       blocked,
   output logic [2:0] state,
   output logic [7:0] block_cnt
);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StFwd   = 3'd1,
      StRev   = 3'd2,
      StBlock = 3'd3,
      StHold  = 3'd4
   } state_e;

   localparam logic [7:0] DebLast  = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0] HoldLoad = 8'(RESUME_CYCLES - 1);

   logic       syncF1, syncF2, syncB1, syncB2;
   logic       obsF, obsB;
   logic [7:0] debCntF, debCntB;

   state_e     stateQ, stateNext;
   logic       pendFwd, pendFwdNext;     // 1 = pending direction is FWD
   logic [7:0] holdTimer, holdTimerNext;
   logic       cmdAccept, pendDet, enterBlock;

   assign obsF = ~syncF2;
   assign obsB = ~syncB2;

   // Two-flop synchronisers and per-channel debounce counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         syncF1  <= 1'b1;
         syncF2  <= 1'b1;
         syncB1  <= 1'b1;
         syncB2  <= 1'b1;
         debCntF <= '0;
         debCntB <= '0;
         detF    <= 1'b0;
         detB    <= 1'b0;
      end else begin
         syncF1 <= disF;
         syncF2 <= syncF1;
         syncB1 <= disB;
         syncB2 <= syncB1;

         if (obsF == detF) begin
            debCntF <= '0;
         end else if (debCntF == DebLast) begin
            detF    <= ~detF;
            debCntF <= '0;
         end else begin
            debCntF <= debCntF + 8'd1;
         end

         if (obsB == detB) begin
            debCntB <= '0;
         end else if (debCntB == DebLast) begin
            detB    <= ~detB;
            debCntB <= '0;
         end else begin
            debCntB <= debCntB + 8'd1;
         end
      end
   end

   assign cmdAccept = cmd_valid && cmd_ready;
   assign pendDet   = pendFwd ? detF : detB;

   // An accepted command takes priority; the obstacle check then uses the new direction.
   always_comb begin
      stateNext     = stateQ;
      pendFwdNext   = pendFwd;
      holdTimerNext = holdTimer;
      if (cmdAccept) begin
         case (cmd_dir)
            2'b01: begin
               if (detF) begin
                  stateNext   = StBlock;
                  pendFwdNext = 1'b1;
               end else begin
                  stateNext = StFwd;
               end
            end
            2'b10: begin
               if (detB) begin
                  stateNext   = StBlock;
                  pendFwdNext = 1'b0;
               end else begin
                  stateNext = StRev;
               end
            end
            default: stateNext = StIdle;
         endcase
      end else begin
         case (stateQ)
            StFwd: begin
               if (detF) begin
                  stateNext   = StBlock;
                  pendFwdNext = 1'b1;
               end
            end
            StRev: begin
               if (detB) begin
                  stateNext   = StBlock;
                  pendFwdNext = 1'b0;
               end
            end
            StBlock: begin
               if (!pendDet) begin
                  stateNext     = StHold;
                  holdTimerNext = HoldLoad;
               end
            end
            StHold: begin
               if (pendDet) begin
                  stateNext     = StBlock;
                  holdTimerNext = '0;
               end else if (holdTimer == '0) begin
                  stateNext = pendFwd ? StFwd : StRev;
               end else begin
                  holdTimerNext = holdTimer - 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Re-entry from HOLD back to BLOCK is not counted.
   assign enterBlock = (stateNext == StBlock) &&
                       ((stateQ == StIdle) || (stateQ == StFwd) || (stateQ == StRev));

   // FSM state plus registered outputs decoded from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ    <= StIdle;
         pendFwd   <= 1'b1;
         holdTimer <= '0;
         motor_en  <= 1'b0;
         motor_dir <= 1'b0;
         blocked   <= 1'b0;
         cmd_ready <= 1'b1;
         block_cnt <= '0;
      end else begin
         stateQ    <= stateNext;
         pendFwd   <= pendFwdNext;
         holdTimer <= holdTimerNext;
         motor_en  <= (stateNext == StFwd) || (stateNext == StRev);
         motor_dir <= (stateNext == StFwd);
         blocked   <= (stateNext == StBlock) || (stateNext == StHold);
         cmd_ready <= (stateNext != StHold);
         if (enterBlock && (block_cnt != 8'hFF)) begin
            block_cnt <= block_cnt + 8'd1;
         end
      end
   end

   assign state = stateQ;

endmodule

// File: doc/drive_safety_ctrl.md
Name: drive_safety_ctrl

Overview:
- Sequences the rover drive motors against the front/back obstacle sensors.
- Synchronises and debounces the active-low IR inputs, accepts drive commands through a valid/ready handshake, and gates motor enable when the commanded direction is obstructed.
- After an obstruction clears, it waits a fixed hold-off before resuming.
- Sits between the navigation command source and the motor PWM/driver block.

Parameters:
- DEBOUNCE_CYCLES, 8: consecutive stable synchronised samples required to change a detect output; legal range 1..255.
- RESUME_CYCLES, 16: hold-off cycles after an obstruction clears before motion resumes; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- disF  in  1  raw front IR sensor, active-low (0 = obstacle), asynchronous
- disB  in  1  raw back IR sensor, active-low (0 = obstacle), asynchronous
- cmd_valid  in  1  command present
- cmd_dir  in  2  00 STOP, 01 FWD, 10 REV, 11 reserved (treated as STOP)
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- motor_en  out  1  drive enable
- motor_dir  out  1  1 = forward, 0 = reverse; meaningful only when motor_en = 1
- detF  out  1  debounced front obstacle, active-high
- detB  out  1  debounced back obstacle, active-high
- blocked  out  1  high in BLOCK and HOLD
- state  out  3  FSM state: IDLE=0, FWD=1, REV=2, BLOCK=3, HOLD=4
- block_cnt  out  8  saturating count of BLOCK entries

Behaviour:
- Reset values:
  - Outputs: state IDLE, motor_en 0, motor_dir 0, detF/detB 0, blocked 0, block_cnt 0, cmd_ready 1.
  - Internals: sync flops 1, debounce counters 0, hold timer 0, pending direction FWD.
- Reset mid-operation: motor_en drops in the cycle after reset is sampled; no command survives reset.
- Synchroniser: two flops per sensor. obs = ~sync2.
- Debounce (per channel):
  - If obs equals the current det, the counter clears.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, det toggles and the counter clears.
  - Latency from a raw edge to det is 2 + DEBOUNCE_CYCLES cycles.
  - Any glitch shorter than DEBOUNCE_CYCLES resets the count.
- cmd_ready = 1 in all states except HOLD.
- All outputs are registered. motor_en = 1 only in FWD (motor_dir 1) and in REV (motor_dir 0).
- Command evaluation on an accepted command:
  - STOP or reserved goes to IDLE from any state.
  - FWD goes to BLOCK (pending = FWD) if detF, else to FWD.
  - REV goes to BLOCK (pending = REV) if detB, else to REV.
  - Re-issuing the current direction is legal and changes nothing.
- State transitions with no accepted command:
  - IDLE stays in IDLE.
  - FWD goes to BLOCK (pending FWD) when detF = 1.
  - REV goes to BLOCK (pending REV) when detB = 1.
  - BLOCK goes to HOLD when the pending-direction det = 0, loading the timer with RESUME_CYCLES-1.
  - HOLD returns to BLOCK if the pending-direction det reasserts, with the timer cleared and block_cnt not incremented.
  - HOLD otherwise decrements the timer each cycle; at 0 it enters the pending direction state.
- Obstruction response: det rising edge to motor_en = 0 is exactly 1 cycle.
- Obstacle on the non-moving side is ignored: detB does not affect FWD, detF does not affect REV.
- Simultaneous command and detect in the same cycle: the command is applied first, then the obstacle check uses the new direction.
  - Example: in FWD with detF = 1 and an accepted REV with detB = 0, the next state is REV.
- block_cnt:
  - Increments on every transition into BLOCK from IDLE, FWD or REV.
  - Saturates at 255; only reset clears it.
- HOLD with cmd_valid = 1: the command waits (ready low) and is accepted on the first cycle after leaving HOLD.

Test Plan:
- Reset, then cmd FWD with disF = 1: cmd accepted in cycle 0, state = FWD, motor_en = 1, motor_dir = 1 on cycle 1; block_cnt = 0.
- In FWD, drive disF = 0 steadily (DEBOUNCE_CYCLES = 8): detF rises 10 cycles after the edge; state = BLOCK and motor_en = 0 one cycle later; block_cnt = 1.
- disF pulses low for 5 cycles, three times, separated by 1-cycle highs: detF stays 0 and motor_en stays 1 throughout.
- In BLOCK (pending FWD), release disF: detF falls after 10 cycles; HOLD for exactly 16 cycles with cmd_ready = 0; then FWD with motor_en = 1.
  - Repeat with disF re-asserted mid-HOLD: state returns to BLOCK and block_cnt does not increment.
- In FWD with detF rising in the same cycle as an accepted REV (disB = 1): state = REV, motor_dir = 0, block_cnt unchanged.
  - Then issue REV with detB = 1: BLOCK with pending REV.
- Force 256 BLOCK entries: block_cnt holds at 255. Assert reset while in REV: the next cycle shows motor_en = 0, state = IDLE, block_cnt = 0.
